// File: rtl/decode_ctrl_pipe_if.sv
// decode_ctrl_pipe_if: fetch/execute handshakes, decoded control bundle and load writeback port
interface decode_ctrl_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_val;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        mux_a_sel;
  logic        mux_b_sel;
  logic [3:0]  alu_func;
  logic [2:0]  sx_size;
  logic [1:0]  rd_sel;
  logic [1:0]  pc_next_sel;
  logic        is_branch;
  logic [2:0]  br_cond;
  logic        is_jal;
  logic        reg_we;
  logic        mem_we;
  logic        load_o;
  logic        wb_load;
  logic [4:0]  wb_rd;
  logic [2:0]  wb_sx_size;
  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, imm_val, rs1, rs2, rd, mux_a_sel, mux_b_sel, alu_func, sx_size,
           rd_sel, pc_next_sel, is_branch, br_cond, is_jal, reg_we, mem_we, load_o,
           wb_load, wb_rd, wb_sx_size
  );
  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, imm_val, rs1, rs2, rd, mux_a_sel, mux_b_sel, alu_func, sx_size,
           rd_sel, pc_next_sel, is_branch, br_cond, is_jal, reg_we, mem_we, load_o,
           wb_load, wb_rd, wb_sx_size
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32I decode stage with fixed-latency load writeback and load-use interlock
module decode_ctrl_pipe #(
  parameter int LOAD_LAT     = 2,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input logic clk,
  input logic rst,
  decode_ctrl_pipe_if.slave bus
);
  typedef struct packed {
    logic [31:0] imm_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        mux_a_sel;
    logic        mux_b_sel;
    logic [3:0]  alu_func;
    logic [2:0]  sx_size;
    logic [1:0]  rd_sel;
    logic [1:0]  pc_next_sel;
    logic        is_branch;
    logic [2:0]  br_cond;
    logic        is_jal;
    logic        reg_we;
    logic        mem_we;
    logic        load_o;
  } ctrl_t;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [2:0] sx;
  } wb_t;
  logic [31:0] ir;
  logic [4:0]  op, r1, r2;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_imm, is_alu, is_sys, is_fence;
  logic        known, use1, use2, hazard, q_valid, accept_load;
  logic [3:0]  alu_f;
  logic [2:0]  sx;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  ctrl_t       dec, q;
  wb_t         s [1:LOAD_LAT];
  wb_t         ins;
  assign ir       = bus.instruction;
  assign op       = ir[6:2];
  assign f3       = ir[14:12];
  assign r1       = ir[19:15];
  assign r2       = ir[24:20];
  assign is_lui   = op == 5'b01101;
  assign is_auipc = op == 5'b00101;
  assign is_jal   = op == 5'b11011;
  assign is_jalr  = op == 5'b11001;
  assign is_br    = op == 5'b11000;
  assign is_load  = op == 5'b00000;
  assign is_store = op == 5'b01000;
  assign is_imm   = op == 5'b00100;
  assign is_alu   = op == 5'b01100;
  assign is_sys   = op == 5'b11100;
  assign is_fence = op == 5'b00011;
  // Only 32-bit encodings are legal; anything else decodes as illegal
  assign known = (ir[1:0] == 2'b11) &
                 (is_lui | is_auipc | is_jal | is_jalr | is_br | is_load | is_store | is_imm | is_alu | is_sys | is_fence);
  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm = {ir[31:12], 12'b0};
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign alu_f = f3 == 3'b000 ? ((is_alu & ir[30]) ? 4'b0001 : 4'b0000) :
                 f3 == 3'b001 ? 4'b0010 :
                 f3 == 3'b010 ? 4'b0011 :
                 f3 == 3'b011 ? 4'b0100 :
                 f3 == 3'b100 ? 4'b0101 :
                 f3 == 3'b101 ? (ir[30] ? 4'b0111 : 4'b0110) :
                 f3 == 3'b110 ? 4'b1000 : 4'b1001;
  assign sx = f3 == 3'b000 ? 3'b000 :
              f3 == 3'b100 ? 3'b001 :
              f3 == 3'b001 ? 3'b010 :
              f3 == 3'b101 ? 3'b011 : 3'b100;
  always_comb begin
    dec             = '0;
    dec.rs1         = r1;
    dec.rs2         = r2;
    dec.rd          = ir[11:7];
    dec.imm_val     = !known ? '0 :
                      is_store ? s_imm :
                      is_br ? b_imm :
                      (is_lui | is_auipc) ? u_imm :
                      is_jal ? j_imm :
                      is_alu ? '0 : i_imm;
    dec.mux_a_sel   = is_jal | is_lui | is_auipc | is_br;
    dec.mux_b_sel   = known & !is_alu;
    dec.alu_func    = is_jalr ? 4'b1010 : (is_alu | is_imm) ? alu_f : 4'b0000;
    dec.sx_size     = (is_load | is_store) ? sx : 3'b000;
    dec.rd_sel      = is_lui ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
    dec.pc_next_sel = (is_sys | (!known & TRAP_ILLEGAL)) ? 2'b10 : is_jalr ? 2'b01 : 2'b00;
    dec.is_branch   = is_br;
    dec.br_cond     = is_br ? f3 : 3'b000;
    dec.is_jal      = is_jal;
    dec.reg_we      = (is_lui | is_auipc | is_jal | is_jalr | is_imm | is_alu) & (ir[11:7] != 5'd0);
    dec.mem_we      = is_store;
    dec.load_o      = is_load;
    if (!known) begin
      dec.mux_a_sel = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jal    = 1'b0;
      dec.reg_we    = 1'b0;
      dec.mem_we    = 1'b0;
      dec.load_o    = 1'b0;
    end
  end
  assign use1 = is_jalr | is_br | is_load | is_store | is_imm | is_alu;
  assign use2 = is_br | is_store | is_alu;
  // A load stops blocking once it reaches the final stage: its writeback lands before the next read
  always_comb begin
    hazard = 1'b0;
    if (q_valid & q.load_o & (q.rd != 5'd0))
      hazard = (use1 & (r1 == q.rd)) | (use2 & (r2 == q.rd));
    for (int i = 1; i < LOAD_LAT; i++)
      if (s[i].v) hazard = hazard | (use1 & (r1 == s[i].rd)) | (use2 & (r2 == s[i].rd));
  end
  assign bus.in_ready = !rst & !bus.flush & !hazard & (!q_valid | bus.out_ready);
  assign accept_load  = q_valid & bus.out_ready & q.load_o & !bus.flush & (q.rd != 5'd0);
  assign ins          = accept_load ? '{v: 1'b1, rd: q.rd, sx: q.sx_size} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (bus.flush) begin
      q_valid <= 1'b0;
    end else if (bus.in_valid & bus.in_ready) begin
      q_valid <= 1'b1;
      q       <= dec;
    end else if (bus.out_ready) begin
      q_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= LOAD_LAT; i++) s[i] <= '0;
    end else begin
      s[1] <= ins;
      for (int i = 2; i <= LOAD_LAT; i++) s[i] <= s[i-1];
    end
  end
  assign bus.out_valid   = q_valid;
  assign bus.imm_val     = q.imm_val;
  assign bus.rs1         = q.rs1;
  assign bus.rs2         = q.rs2;
  assign bus.rd          = q.rd;
  assign bus.mux_a_sel   = q.mux_a_sel;
  assign bus.mux_b_sel   = q.mux_b_sel;
  assign bus.alu_func    = q.alu_func;
  assign bus.sx_size     = q.sx_size;
  assign bus.rd_sel      = q.rd_sel;
  assign bus.pc_next_sel = q.pc_next_sel;
  assign bus.is_branch   = q.is_branch;
  assign bus.br_cond     = q.br_cond;
  assign bus.is_jal      = q.is_jal;
  assign bus.reg_we      = q.reg_we;
  assign bus.mem_we      = q.mem_we;
  assign bus.load_o      = q.load_o;
  assign bus.wb_load     = s[LOAD_LAT].v;
  assign bus.wb_rd       = s[LOAD_LAT].rd;
  assign bus.wb_sx_size  = s[LOAD_LAT].sx;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed checks of decode, load-use interlock, back-pressure, flush and traps
module tb_decode_ctrl_pipe;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  localparam logic [31:0] ADDI  = 32'h00700293;
  localparam logic [31:0] SUB   = 32'h402081B3;
  localparam logic [31:0] AND_  = 32'h003170B3;
  localparam logic [31:0] LW6   = 32'h0000A303;
  localparam logic [31:0] ADD7  = 32'h006303B3;
  localparam logic [31:0] LW8   = 32'h0000A403;
  localparam logic [31:0] SW9   = 32'h0090A023;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] ILL   = 32'h0000007F;
  localparam logic [31:0] LUI   = 32'h123450B7;
  decode_ctrl_pipe_if a ();
  decode_ctrl_pipe_if b ();
  decode_ctrl_pipe #(.LOAD_LAT(2), .TRAP_ILLEGAL(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(a));
  decode_ctrl_pipe #(.LOAD_LAT(2), .TRAP_ILLEGAL(1'b0)) u_nop (.clk(clk), .rst(rst), .bus(b));
  assign b.in_valid    = a.in_valid;
  assign b.instruction = a.instruction;
  assign b.flush       = a.flush;
  assign b.out_ready   = a.out_ready;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst           = 1'b1;
    a.in_valid    = 1'b1;
    a.instruction = ADDI;
    a.out_ready   = 1'b1;
    a.flush       = 1'b0;
    tick; #1;
    chk("rst0_in_ready", 32'(a.in_ready), 0);
    chk("rst0_out_valid", 32'(a.out_valid), 0);
    chk("rst0_wb_load", 32'(a.wb_load), 0);
    chk("rst0_imm", a.imm_val, 0);
    tick; #1;
    chk("rst1_in_ready", 32'(a.in_ready), 0);
    chk("rst1_out_valid", 32'(a.out_valid), 0);
    chk("rst1_wb_rd", 32'(a.wb_rd), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(a.in_ready), 1);
    tick; a.instruction = SUB; #1;
    chk("addi_valid", 32'(a.out_valid), 1);
    chk("addi_alu", 32'(a.alu_func), 4'b0000);
    chk("addi_mux_b", 32'(a.mux_b_sel), 1);
    chk("addi_imm", a.imm_val, 7);
    chk("addi_rd", 32'(a.rd), 5);
    chk("addi_we", 32'(a.reg_we), 1);
    tick; a.instruction = AND_; #1;
    chk("sub_alu", 32'(a.alu_func), 4'b0001);
    chk("sub_mux_b", 32'(a.mux_b_sel), 0);
    chk("sub_rd", 32'(a.rd), 3);
    chk("sub_imm", a.imm_val, 0);
    tick; a.instruction = LW6; #1;
    chk("and_alu", 32'(a.alu_func), 4'b1001);
    chk("and_rd", 32'(a.rd), 1);
    tick; a.instruction = ADD7; #1;
    chk("lw_load", 32'(a.load_o), 1);
    chk("lw_we", 32'(a.reg_we), 0);
    chk("lw_sx", 32'(a.sx_size), 3'b100);
    chk("lu_c1_in_ready", 32'(a.in_ready), 0);
    tick; #1;
    chk("lu_c2_in_ready", 32'(a.in_ready), 0);
    chk("lu_c2_wb_load", 32'(a.wb_load), 0);
    chk("lu_c2_out_valid", 32'(a.out_valid), 0);
    tick; #1;
    chk("lu_c3_wb_load", 32'(a.wb_load), 1);
    chk("lu_c3_wb_rd", 32'(a.wb_rd), 6);
    chk("lu_c3_wb_sx", 32'(a.wb_sx_size), 3'b100);
    chk("lu_c3_in_ready", 32'(a.in_ready), 1);
    tick; a.out_ready = 1'b0; a.instruction = ADDI; #1;
    chk("lu_c4_out_valid", 32'(a.out_valid), 1);
    chk("lu_c4_rd", 32'(a.rd), 7);
    chk("lu_c4_wb_load", 32'(a.wb_load), 0);
    chk("bp_in_ready0", 32'(a.in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      tick; #1;
      chk("bp_valid", 32'(a.out_valid), 1);
      chk("bp_rd", 32'(a.rd), 7);
      chk("bp_rs1", 32'(a.rs1), 6);
      chk("bp_reg_we", 32'(a.reg_we), 1);
      chk("bp_in_ready", 32'(a.in_ready), 0);
    end
    tick; a.out_ready = 1'b1; #1;
    chk("bp_hold3_rd", 32'(a.rd), 7);
    chk("bp_release_in_ready", 32'(a.in_ready), 1);
    tick; a.instruction = LW8; #1;
    chk("bp_next_rd", 32'(a.rd), 5);
    chk("bp_next_imm", a.imm_val, 7);
    tick; a.instruction = SW9; #1;
    chk("lw8_load", 32'(a.load_o), 1);
    chk("sw_in_ready", 32'(a.in_ready), 1);
    tick; a.flush = 1'b1; a.instruction = ADDI; #1;
    chk("sw_mem_we", 32'(a.mem_we), 1);
    chk("sw_sx", 32'(a.sx_size), 3'b100);
    chk("sw_reg_we", 32'(a.reg_we), 0);
    chk("flush_in_ready", 32'(a.in_ready), 0);
    tick; a.flush = 1'b0; a.instruction = ECALL; #1;
    chk("flush_out_valid", 32'(a.out_valid), 0);
    chk("flush_wb_load", 32'(a.wb_load), 1);
    chk("flush_wb_rd", 32'(a.wb_rd), 8);
    chk("post_flush_in_ready", 32'(a.in_ready), 1);
    tick; a.instruction = ILL; #1;
    chk("ecall_pc_sel", 32'(a.pc_next_sel), 2'b10);
    chk("ecall_we", 32'(a.reg_we), 0);
    tick; a.instruction = LUI; #1;
    chk("ill_trap_pc_sel", 32'(a.pc_next_sel), 2'b10);
    chk("ill_nop_valid", 32'(b.out_valid), 1);
    chk("ill_nop_pc_sel", 32'(b.pc_next_sel), 2'b00);
    chk("ill_nop_we", 32'(b.reg_we), 0);
    chk("ill_nop_mem_we", 32'(b.mem_we), 0);
    tick; a.instruction = LW8; #1;
    chk("lui_rd_sel", 32'(a.rd_sel), 2'b01);
    chk("lui_imm", a.imm_val, 32'h12345000);
    chk("lui_mux_a", 32'(a.mux_a_sel), 1);
    tick; a.in_valid = 1'b0; #1;
    chk("lw8b_load", 32'(a.load_o), 1);
    tick; rst = 1'b1; #1;
    tick; #1;
    chk("rst_mid_wb_load", 32'(a.wb_load), 0);
    chk("rst_mid_out_valid", 32'(a.out_valid), 0);
    tick; #1;
    chk("rst_mid_wb_load2", 32'(a.wb_load), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, handshaked RV32I decode/control stage with an integrated load-writeback tracker and load-use interlock. It sits between fetch and execute. It decodes one instruction per cycle into the control bundle and holds it in an output register. For each accepted load it schedules a fixed-latency writeback on a dedicated write port. It stalls fetch while a source register depends on a load that has not yet written back.

## Interface
- LOAD_LAT, 2: cycles from load acceptance by execute to its writeback; legal range 1..4.
- TRAP_ILLEGAL, 1: 1 = unknown opcode decodes as a trap (pc_next_sel=2'b10); 0 = decodes as a NOP.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid / in_ready  in/out  1  fetch handshake.
- instruction  in  32  instruction word.
- flush  in  1  kill the output-register entry; no input accepted this cycle.
- out_valid / out_ready  out/in  1  execute handshake.
- imm_val  out  32  sign-extended immediate (I/S/B/U/J by opcode; 0 for R-type).
- rs1, rs2, rd  out  5 each  register fields.
- mux_a_sel, mux_b_sel  out  1 each  operand selects:
  - a = jal/lui/auipc/branch
  - b = any non-R-type
- alu_func  out  4  ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, ADD_JALR 1010.
- sx_size  out  3  load/store size: byte 000, ubyte 001, half 010, uhalf 011, word 100.
- rd_sel  out  2  writeback source: 01 lui, 10 jal/jalr, 00 otherwise.
- pc_next_sel  out  2  next-PC source: 10 system or illegal trap, 01 jalr, 00 otherwise.
- is_branch  out  1  branch instruction; br_cond carries the branch condition.
- br_cond  out  3  func3 of the branch; execute forms pc_add_sel.
- is_jal  out  1  jal instruction.
- reg_we  out  1  register write enable: lui/auipc/jal/jalr/imm/alu with rd≠0. Loads give 0.
- mem_we  out  1  store.
- load_o  out  1  load.
- wb_load  out  1  delayed-load writeback strobe (second register-file write port).
- wb_rd  out  5  writeback register for wb_load.
- wb_sx_size  out  3  size code for the returning load data.

## Operation
- **Decode**
  - opcode = instruction[6:2]; func3 = [14:12]; func7 bit = [30].
  - func7 selects SUB vs ADD (R-type only) and SRA vs SRL (R and I).
  - OR is func3 110; AND is func3 111.
  - jalr uses ADD_JALR.
  - branch/load/store/jal/auipc use ADD.
- **Output register**
  - Loads all fields when in_valid & in_ready.
  - Otherwise out_valid clears when out_ready=1.
  - Fields are stable while out_valid & !out_ready.
- **in_ready** (combinational) = !rst & !flush & !hazard & (!out_valid | out_ready).
- **Load tracker**
  - LOAD_LAT-stage shift pipe s[1..LOAD_LAT]; each stage holds {valid, rd, sx_size}.
  - Shifts every cycle regardless of handshakes.
  - A load accepted by execute (out_valid & out_ready & load_o) in cycle c enters s[1] at the end of c.
  - wb_load/wb_rd/wb_sx_size = s[LOAD_LAT], so wb_load is high in cycle c+LOAD_LAT.
  - Entries with rd=0 are inserted with valid=0.
- **Hazard**
  - Raised when the input instruction reads a register equal to a nonzero rd held in either:
    - the output register while it contains a valid load, or
    - any valid stage s[1..LOAD_LAT-1].
  - rs1 is used by jalr/branch/load/store/imm/alu.
  - rs2 is used by branch/store/alu.
  - lui/auipc/jal/system never hazard.
- **Flush**
  - out_valid goes to 0 at the next edge; no input is accepted in the flush cycle.
  - Loads already in s[] complete their writeback.
- **Priority:** rst > flush > normal.

## Timing
- Decode latency is 1 cycle: an instruction accepted in cycle d is on the outputs in cycle d+1.
- Throughput is 1 per cycle with no hazard and out_ready=1.
- Load-use: dependent stalls until s[LOAD_LAT] holds the load. Minimum accept-to-dependent-accept gap is LOAD_LAT+1 cycles.
- Register-file write-before-next-read is assumed: wb in cycle k is visible to reads in cycle k+1.
- **Reset state** (next edge after rst, held while rst=1):
  - out_valid=0, in_ready=0.
  - All bundle fields 0.
  - All s[] invalid; wb_load=0, wb_rd=0, wb_sx_size=0.
- Reset mid-operation discards pending loads; no wb_load is issued after reset.
- **Simultaneous events**
  - A load in the output register being accepted while a dependent waits: stall continues, the entry moves to s[1].
  - wb_load and a decode-path reg_we to the same rd in the same cycle: both are presented; execute orders them.

## Test plan
- **Reset:** rst=1 for 2 cycles with in_valid=1 → in_ready=0, out_valid=0, wb_load=0 throughout. The first instruction is accepted on the cycle after rst falls.
- **ALU decode** (out_ready=1):
  - addi x5,x0,7 (0x00700293) → alu_func 0000, mux_b_sel=1, imm_val=7, rd=5, reg_we=1.
  - sub x3,x1,x2 (0x402081B3) → 0001, mux_b_sel=0.
  - and x1,x2,x3 (0x003170B3) → 1001.
- **Load-use** (LOAD_LAT=2, out_ready=1): lw x6,0(x1) (0x0000A303) accepted in cycle 0, then add x7,x6,x6 (0x006303B3).
  - in_ready=0 in cycles 1–2.
  - Cycle 3: wb_load=1, wb_rd=6, wb_sx_size=100; add accepted.
  - Cycle 4: out_valid=1.
- **Back-pressure:** out_ready=0 for 3 cycles while out_valid=1 → all outputs stable, in_ready=0. With out_ready=1 the next instruction appears one cycle later.
- **Flush:** flush=1 with sw in the output register and a lw in s[1] → next cycle out_valid=0. wb_load is still asserted at its scheduled cycle.
- **Trap decode:**
  - ecall (0x00000073) → pc_next_sel=10, reg_we=0.
  - Word 0x0000007F → pc_next_sel=10 with TRAP_ILLEGAL=1; pc_next_sel=00, reg_we=0, mem_we=0 with TRAP_ILLEGAL=0.
